// File: rtl/or_taint_rr_arbiter.sv
// Round-robin arbiter sharing one 1-bit OR unit among N requesters, with DIFT taint labels.
// Define OR_ARB_PRECISE_TAINT_EN for value-aware OR taint; default is conservative a_t|b_t.
module or_taint_rr_arbiter #(
    parameter int N  = 4,
    parameter int TW = 32,
    localparam int IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*TW-1:0] req_t,
    input  logic [N-1:0]    a,
    input  logic [N*TW-1:0] a_t,
    input  logic [N-1:0]    b,
    input  logic [N*TW-1:0] b_t,
    output logic [N-1:0]    gnt,
    output logic [TW-1:0]   gnt_t,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [IDW-1:0]  res_id,
    output logic            c,
    output logic [TW-1:0]   c_t
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;
    logic           slot_free;
    logic           accept;
    logic [TW-1:0]  req_taint_all;
    logic           win_a;
    logic           win_b;
    logic [TW-1:0]  win_a_t;
    logic [TW-1:0]  win_b_t;

    function automatic logic [TW-1:0] op_taint(input logic av, input logic bv,
                                               input logic [TW-1:0] at,
                                               input logic [TW-1:0] bt);
`ifdef OR_ARB_PRECISE_TAINT_EN
        // A controlling 1 alone decides the OR; with two 1s either one suffices.
        case ({av, bv})
            2'b10:   op_taint = at;
            2'b01:   op_taint = bt;
            2'b11:   op_taint = at & bt;
            default: op_taint = at | bt;
        endcase
`else
        op_taint = (av | bv | 1'b1) ? (at | bt) : '0;
`endif
    endfunction

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % N);
            end
        end
    end

    // Every pending request shapes the decision, so all their labels flow into the grant.
    always_comb begin
        req_taint_all = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) req_taint_all = req_taint_all | req_t[i*TW +: TW];
        end
    end

    assign slot_free = !res_valid || res_ready;
    assign accept    = rst_n && slot_free && (|req);
    assign gnt       = accept ? (N'(1) << win) : '0;
    assign gnt_t     = accept ? req_taint_all : '0;

    assign win_a   = a[win];
    assign win_b   = b[win];
    assign win_a_t = a_t[int'(win)*TW +: TW];
    assign win_b_t = b_t[int'(win)*TW +: TW];

    // Result slot register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            c         <= 1'b0;
            c_t       <= '0;
        end else if (accept) begin
            ptr       <= (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
            res_valid <= 1'b1;
            res_id    <= win;
            c         <= win_a | win_b;
            c_t       <= op_taint(win_a, win_b, win_a_t, win_b_t) | gnt_t;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
